anim_sequencer: RTL and testbench

// - Upstream stage of the VGA renderer. Owns all per-frame animation state.
// - Detects frame boundaries from the timing generator's vsync.
// - Advances a free-running frame counter and a speed-controlled ring-texture phase.
// - Runs a 4-state FSM that moves the "UW" text down and back up.
// - Outputs are stable for a whole frame; the renderer samples them combinationally during active video.

---
 rtl/anim_sequencer_pkg.sv | 17 +
 rtl/vsync_edge_detect.sv | 24 ++
 rtl/anim_sequencer.sv | 100 ++++++++++
 tb/tb_anim_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_sequencer_pkg.sv
// Shared animation definitions: text FSM state encoding and ring-phase step decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package anim_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_FALL  = 2'd1,
        ST_DWELL = 2'd2,
        ST_RISE  = 2'd3
    } text_state_t;

    function automatic logic [7:0] phase_step(input logic [1:0] speed);
        return 8'd1 << speed;
    endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Registered rising-edge detector on the active-low vsync pulse (end of sync).
// Latency: frame_tick pulses 1 cycle after the vsync rise.
// Backpressure: none; a one-cycle pulse that cannot repeat on consecutive cycles.
module vsync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    // vsync_q resets high so a vsync already high after reset is not taken as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Per-frame animation state: frame counter, ring-texture phase and the "UW" text FSM.
// Latency: updated values visible 1 cycle after frame_tick (2 cycles after the vsync rise).
// Backpressure: none; pause freezes phase and FSM at tick edges, frame_cnt always runs.
module anim_sequencer
    import anim_sequencer_pkg::*;
#(
    parameter int TEXT_Y_TOP    = 20,
    parameter int TEXT_Y_BOTTOM = 276,
    parameter int FALL_STEP     = 2,
    parameter int RISE_STEP     = 4,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [1:0]  speed,
    input  logic        pause,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [7:0]  ring_phase,
    output logic [9:0]  text_y,
    output logic [1:0]  text_state
);

    // 11-bit comparisons so text_y + FALL_STEP can never wrap before the clamp test
    localparam logic [10:0] Y_TOP     = 11'(TEXT_Y_TOP);
    localparam logic [10:0] Y_BOTTOM  = 11'(TEXT_Y_BOTTOM);
    localparam logic [10:0] FALL_W    = 11'(FALL_STEP);
    localparam logic [10:0] RISE_W    = 11'(RISE_STEP);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

    text_state_t state_q, state_d;
    logic [9:0]  y_d;
    logic [7:0]  hold_cnt, hold_d;
    logic [10:0] fall_sum;

    vsync_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign text_state = state_q;

    always_comb begin
        state_d  = state_q;
        y_d      = text_y;
        hold_d   = hold_cnt;
        fall_sum = {1'b0, text_y} + FALL_W;
        case (state_q)
            ST_HOLD, ST_DWELL: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_d  = 8'd0;
                    state_d = (state_q == ST_HOLD) ? ST_FALL : ST_RISE;
                end else begin
                    hold_d = hold_cnt + 8'd1;
                end
            end
            ST_FALL: begin
                if (fall_sum >= Y_BOTTOM) begin
                    y_d     = Y_BOTTOM[9:0];
                    state_d = ST_DWELL;
                end else begin
                    y_d = fall_sum[9:0];
                end
            end
            ST_RISE: begin
                if ({1'b0, text_y} <= Y_TOP + RISE_W) begin
                    y_d     = Y_TOP[9:0];
                    state_d = ST_HOLD;
                end else begin
                    y_d = text_y - RISE_W[9:0];
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= 16'd0;
            ring_phase <= 8'd0;
            text_y     <= Y_TOP[9:0];
            state_q    <= ST_HOLD;
            hold_cnt   <= 8'd0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (!pause) begin
                ring_phase <= ring_phase + phase_step(speed);
                text_y     <= y_d;
                state_q    <= state_d;
                hold_cnt   <= hold_d;
            end
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: one task per scenario, inputs driven and outputs
// sampled on the falling clock edge, expected values written out by hand.
module tb_anim_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic [1:0]  speed;
    logic        pause;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [7:0]  ring_phase;
    logic [9:0]  text_y;
    logic [1:0]  text_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    anim_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .speed      (speed),
        .pause      (pause),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .ring_phase (ring_phase),
        .text_y     (text_y),
        .text_state (text_state)
    );

    task automatic pulse_reset;
        vsync = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One vsync low pulse; returns at the falling edge where the updated state is visible
    task automatic do_tick;
        bit seen;
        seen  = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL tick_timeout: no frame_tick within 4 cycles of vsync rise");
        end
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_double: frame_tick=%b required 0", frame_tick);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic test_reset;
        int ticks;
        ticks = 0;
        speed = 2'd0;
        pause = 1'b0;
        pulse_reset();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks !== 0) begin errors++; $display("FAIL reset_no_tick: ticks=%0d required 0", ticks); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        checks++;
        if (ring_phase !== 8'd0) begin errors++; $display("FAIL reset_ring_phase: got %0d required 0", ring_phase); end
        checks++;
        if (text_y !== 10'd20) begin errors++; $display("FAIL reset_text_y: got %0d required 20", text_y); end
        checks++;
        if (text_state !== 2'd0) begin errors++; $display("FAIL reset_text_state: got %0d required 0", text_state); end
    endtask

    task automatic test_single_frame;
        int ticks;
        ticks = 0;
        vsync = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        vsync = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL frame_tick_latency: frame_tick=%b required 1", frame_tick); end
        if (frame_tick === 1'b1) ticks++;
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL frame_cnt_early: got %0d required 0", frame_cnt); end
        @(negedge clk);
        if (frame_tick === 1'b1) ticks++;
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL frame_cnt_one: got %0d required 1", frame_cnt); end
        checks++;
        if (ring_phase !== 8'd1) begin errors++; $display("FAIL ring_phase_one: got %0d required 1", ring_phase); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        checks++;
        if (ticks !== 1) begin errors++; $display("FAIL single_tick_count: ticks=%0d required 1", ticks); end
    endtask

    task automatic test_speed_wrap;
        logic [7:0] exp_phase;
        pulse_reset();
        speed = 2'd3;
        exp_phase = 8'd0;
        for (int i = 0; i < 32; i++) begin
            do_tick();
            exp_phase = exp_phase + 8'd8;
            checks++;
            if (ring_phase !== exp_phase) begin
                errors++;
                $display("FAIL speed3_phase tick %0d: got %0d required %0d", i + 1, ring_phase, exp_phase);
            end
        end
        checks++;
        if (ring_phase !== 8'd0) begin errors++; $display("FAIL speed3_wrap: got %0d required 0", ring_phase); end
        checks++;
        if (frame_cnt !== 16'd32) begin errors++; $display("FAIL speed3_frame_cnt: got %0d required 32", frame_cnt); end
        speed = 2'd1;
        do_tick();
        checks++;
        if (ring_phase !== 8'd2) begin errors++; $display("FAIL speed1_step: got %0d required 2", ring_phase); end
        speed = 2'd0;
    endtask

    task automatic test_text_fsm;
        pulse_reset();
        do_ticks(119);
        checks++;
        if (text_state !== 2'd0) begin errors++; $display("FAIL hold_119: state=%0d required 0", text_state); end
        do_tick();
        checks++;
        if (text_state !== 2'd1 || text_y !== 10'd20) begin
            errors++; $display("FAIL enter_fall: state=%0d y=%0d required 1/20", text_state, text_y);
        end
        do_ticks(127);
        checks++;
        if (text_state !== 2'd1 || text_y !== 10'd274) begin
            errors++; $display("FAIL fall_127: state=%0d y=%0d required 1/274", text_state, text_y);
        end
        do_tick();
        checks++;
        if (text_state !== 2'd2 || text_y !== 10'd276) begin
            errors++; $display("FAIL enter_dwell: state=%0d y=%0d required 2/276", text_state, text_y);
        end
        do_ticks(119);
        checks++;
        if (text_state !== 2'd2) begin errors++; $display("FAIL dwell_119: state=%0d required 2", text_state); end
        do_tick();
        checks++;
        if (text_state !== 2'd3 || text_y !== 10'd276) begin
            errors++; $display("FAIL enter_rise: state=%0d y=%0d required 3/276", text_state, text_y);
        end
        do_ticks(63);
        checks++;
        if (text_state !== 2'd3 || text_y !== 10'd24) begin
            errors++; $display("FAIL rise_63: state=%0d y=%0d required 3/24", text_state, text_y);
        end
        do_tick();
        checks++;
        if (text_state !== 2'd0 || text_y !== 10'd20) begin
            errors++; $display("FAIL enter_hold: state=%0d y=%0d required 0/20", text_state, text_y);
        end
        // hold_cnt must restart from 0: a full 119 more ticks stays in HOLD
        do_ticks(119);
        checks++;
        if (text_state !== 2'd0) begin errors++; $display("FAIL rehold_119: state=%0d required 0", text_state); end
        checks++;
        if (frame_cnt !== 16'd551) begin errors++; $display("FAIL fsm_frame_cnt: got %0d required 551", frame_cnt); end
    endtask

    task automatic test_pause;
        pulse_reset();
        do_ticks(160);
        checks++;
        if (text_state !== 2'd1 || text_y !== 10'd100) begin
            errors++; $display("FAIL pause_setup: state=%0d y=%0d required 1/100", text_state, text_y);
        end
        pause = 1'b1;
        do_ticks(10);
        checks++;
        if (frame_cnt !== 16'd170) begin errors++; $display("FAIL pause_frame_cnt: got %0d required 170", frame_cnt); end
        checks++;
        if (text_y !== 10'd100 || text_state !== 2'd1) begin
            errors++; $display("FAIL pause_text: state=%0d y=%0d required 1/100", text_state, text_y);
        end
        checks++;
        if (ring_phase !== 8'd160) begin errors++; $display("FAIL pause_ring: got %0d required 160", ring_phase); end
        pause = 1'b0;
        do_tick();
        checks++;
        if (text_y !== 10'd102 || ring_phase !== 8'd161) begin
            errors++; $display("FAIL pause_release: y=%0d ring=%0d required 102/161", text_y, ring_phase);
        end
        // pause pulsed between ticks is never sampled
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
        do_tick();
        checks++;
        if (text_y !== 10'd104 || frame_cnt !== 16'd172) begin
            errors++; $display("FAIL midframe_pause: y=%0d cnt=%0d required 104/172", text_y, frame_cnt);
        end
    endtask

    task automatic test_reset_mid_fall;
        pulse_reset();
        speed = 2'd2;
        do_ticks(185);
        checks++;
        if (text_state !== 2'd1 || text_y !== 10'd150) begin
            errors++; $display("FAIL fall150_setup: state=%0d y=%0d required 1/150", text_state, text_y);
        end
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL coincident_tick: frame_tick=%b required 1", frame_tick); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (text_y !== 10'd20 || text_state !== 2'd0) begin
            errors++; $display("FAIL reset_fall_text: state=%0d y=%0d required 0/20", text_state, text_y);
        end
        checks++;
        if (frame_cnt !== 16'd0 || ring_phase !== 8'd0) begin
            errors++; $display("FAIL reset_fall_counts: cnt=%0d ring=%0d required 0/0", frame_cnt, ring_phase);
        end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_fall_tick: frame_tick=%b required 0", frame_tick); end
        speed = 2'd0;
        do_tick();
        checks++;
        if (frame_cnt !== 16'd1 || ring_phase !== 8'd1) begin
            errors++; $display("FAIL post_reset_tick: cnt=%0d ring=%0d required 1/1", frame_cnt, ring_phase);
        end
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        speed = 2'd0;
        pause = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_speed_wrap();
        test_text_fsm();
        test_pause();
        test_reset_mid_fall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
